vga_framebuffer_scanout: RTL

//  Receiving end of the plot interface driven by the hangman renderer.

---
 rtl/vga_framebuffer_scanout.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vga_framebuffer_scanout.sv
// Purpose: 320x240x3 frame buffer fed by a plot port, scanned out as 640x480@60 VGA with 2x2 pixel doubling.
// Latency: every VGA_* output lags the h/v counter value it represents by one pixel period (2 clk).
// Backpressure: none; one plot write is accepted every clk, including while reset is held or releasing.
//
// Ports:
//   clk, resetn            system clock (50 MHz) and async active-low reset (release is synchronised)
//   plot, x, y, colour     pixel write; writes outside FB_W x FB_H are dropped
//   VGA_CLK                pixel clock, clk/2
//   VGA_HS, VGA_VS         active-low syncs
//   VGA_BLANK_N            high in the visible area; VGA_SYNC_N tied low
//   VGA_R/G/B              each stored colour bit replicated across 10 bits
module vga_framebuffer_scanout #(
    parameter int FB_W = 320,
    parameter int FB_H = 240,
    parameter int H_FP = 16,
    parameter int H_SW = 96,
    parameter int H_BP = 48,
    parameter int V_FP = 10,
    parameter int V_SW = 2,
    parameter int V_BP = 33
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       plot,
    input  logic [8:0] x,
    input  logic [7:0] y,
    input  logic [2:0] colour,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B
);

    localparam int H_VIS   = 2 * FB_W;
    localparam int V_VIS   = 2 * FB_H;
    localparam int H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SW + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DEPTH   = FB_W * FB_H;
    localparam int AW      = $clog2(DEPTH);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_VIS + H_FP + H_SW - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_VIS + V_FP + V_SW - 1);
    localparam logic [8:0]    X_LIM    = 9'(FB_W);
    localparam logic [7:0]    Y_LIM    = 8'(FB_H);
    localparam logic [31:0]   FB_W_BITS = FB_W;

    // row * FB_W as a sum of shifted copies, one per set bit of FB_W
    // (for 320 this is row*256 + row*64, no multiplier needed).
    function automatic logic [AW-1:0] row_base(input logic [AW-1:0] row);
        logic [AW-1:0] acc;
        acc = '0;
        for (int i = 0; i < AW; i++) begin
            if (FB_W_BITS[i]) acc = acc + (row << i);
        end
        return acc;
    endfunction

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    logic          r_pix_tick;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [2:0]    r_mem [DEPTH];
    logic [2:0]    r_rd_dat;
    logic          w_vis;
    logic          w_wr_en;
    logic [AW-1:0] w_rd_addr;
    logic [AW-1:0] w_wr_addr;
    logic          r_vga_clk;
    logic          r_hs;
    logic          r_vs;
    logic          r_blank_n;
    logic [9:0]    r_r;
    logic [9:0]    r_g;
    logic [9:0]    r_b;

    // Reset asserts immediately, releases two clk edges after resetn rises.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_rst_sync <= 2'b00;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_vis     = (r_h < H_VIS_C) && (r_v < V_VIS_C);
    assign w_rd_addr = w_vis ? (row_base(AW'(r_v >> 1)) + AW'(r_h >> 1)) : '0;
    assign w_wr_en   = plot && (x < X_LIM) && (y < Y_LIM);
    assign w_wr_addr = row_base(AW'(y)) + AW'(x);

    // Frame buffer: never reset, so the picture survives a reset.
    // Read and write share an edge with read-before-write semantics.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[w_wr_addr] <= colour;
    end

    // The counter holds each value for two clks; the read issued on the first
    // edge is ready by the tick edge that registers the outputs for that value.
    always_ff @(posedge clk) begin
        r_rd_dat <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pix_tick <= 1'b0;
            r_vga_clk  <= 1'b0;
            r_h        <= '0;
            r_v        <= '0;
            r_hs       <= 1'b1;
            r_vs       <= 1'b1;
            r_blank_n  <= 1'b0;
            r_r        <= '0;
            r_g        <= '0;
            r_b        <= '0;
        end else begin
            r_pix_tick <= ~r_pix_tick;
            r_vga_clk  <= r_pix_tick;
            if (r_pix_tick) begin
                if (r_h == H_LAST) begin
                    r_h <= '0;
                    r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
                end else begin
                    r_h <= r_h + 1'b1;
                end
                // Syncs, blank and colour all describe the counter value being left behind.
                r_hs      <= !((r_h >= HS_FIRST) && (r_h <= HS_LAST));
                r_vs      <= !((r_v >= VS_FIRST) && (r_v <= VS_LAST));
                r_blank_n <= w_vis;
                r_r       <= {10{w_vis & r_rd_dat[2]}};
                r_g       <= {10{w_vis & r_rd_dat[1]}};
                r_b       <= {10{w_vis & r_rd_dat[0]}};
            end
        end
    end

    assign VGA_CLK     = r_vga_clk;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = r_r;
    assign VGA_G       = r_g;
    assign VGA_B       = r_b;

endmodule
